idecode: RTL and testbench

IDECODE -- requirements
Module: idecode

---
 rtl/idecode_pkg.sv | 21 ++
 rtl/idecode_regfile.sv | 32 +++
 rtl/idecode.sv | 39 +++
 tb/tb_idecode.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/idecode_pkg.sv
// idecode_pkg: shared widths, instruction field positions and helpers for the decode stage
package idecode_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int RS_HI      = 25;
  localparam int RS_LO      = 21;
  localparam int RT_HI      = 20;
  localparam int RT_LO      = 16;
  localparam int RD_HI      = 15;
  localparam int RD_LO      = 11;
  localparam int IMM_HI     = 15;
  localparam int IMM_LO     = 0;
  localparam int FUNCT_HI   = 5;
  localparam int FUNCT_LO   = 0;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  function automatic word_t sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction
endpackage

// File: rtl/idecode_regfile.sv
// regfile: 32x32 register file, sync active-low reset to entry[i]=i, one write port, two bypassed read ports
// ports: clock, reset (active-low sync); rs_addr/rt_addr read addresses; wr_addr/wr_en/wr_data write port;
//        rs_data/rt_data combinational read data
module regfile
  import idecode_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data
);
  word_t regs [REG_COUNT];
  logic  wr_live;
  // a write only lands (and is only forwarded) when reset is not sampled this edge
  assign wr_live = reset && wr_en && (wr_addr != '0);
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= word_t'(i);
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : (wr_live && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : (wr_live && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
  end
endmodule

// File: rtl/idecode.sv
// idecode: instruction field slicing, sign extension and write-back mux around the register file
// ports: clock, reset (active-low sync); instruction; alu_result/read_data/wreg_address/regwrite/memtoreg
//        write-back; register_rs/register_rt read data; sign_extend; function_opcode/wreg_rd/wreg_rt slices
module idecode
  import idecode_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     instruction,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [REG_ADDR_W-1:0] wreg_address,
  input  logic                  regwrite,
  input  logic                  memtoreg,
  output logic [DATA_W-1:0]     register_rs,
  output logic [DATA_W-1:0]     register_rt,
  output logic [DATA_W-1:0]     sign_extend,
  output logic [5:0]            function_opcode,
  output logic [REG_ADDR_W-1:0] wreg_rd,
  output logic [REG_ADDR_W-1:0] wreg_rt
);
  word_t write_data;
  assign write_data      = memtoreg ? read_data : alu_result;
  assign sign_extend     = sext16(instruction[IMM_HI:IMM_LO]);
  assign function_opcode = instruction[FUNCT_HI:FUNCT_LO];
  assign wreg_rd         = instruction[RD_HI:RD_LO];
  assign wreg_rt         = instruction[RT_HI:RT_LO];
  regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (instruction[RS_HI:RS_LO]),
    .rt_addr (instruction[RT_HI:RT_LO]),
    .wr_addr (wreg_address),
    .wr_en   (regwrite),
    .wr_data (write_data),
    .rs_data (register_rs),
    .rt_data (register_rt)
  );
endmodule

// File: tb/tb_idecode.sv
// tb_idecode: directed and randomized checks of idecode against a behavioural register-file model
module tb_idecode;
  logic        clock = 0;
  logic        reset = 0;
  logic [31:0] instruction = 0, alu_result = 0, read_data = 0;
  logic [4:0]  wreg_address = 0;
  logic        regwrite = 0, memtoreg = 0;
  logic [31:0] register_rs, register_rt, sign_extend;
  logic [5:0]  function_opcode;
  logic [4:0]  wreg_rd, wreg_rt;
  logic [31:0] model [32];
  int n_cmp = 0, n_fail = 0;
  idecode dut (
    .clock(clock), .reset(reset), .instruction(instruction), .alu_result(alu_result),
    .read_data(read_data), .wreg_address(wreg_address), .regwrite(regwrite), .memtoreg(memtoreg),
    .register_rs(register_rs), .register_rt(register_rt), .sign_extend(sign_extend),
    .function_opcode(function_opcode), .wreg_rd(wreg_rd), .wreg_rt(wreg_rt)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end
  function automatic logic [31:0] mk(input int rs, input int rt, input int imm);
    return (rs % 32) * 32'h0020_0000 + (rt % 32) * 32'h0001_0000 + (imm % 65536);
  endfunction
  function automatic logic [31:0] wdata();
    return memtoreg ? read_data : alu_result;
  endfunction
  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 0;
    if (reset && regwrite && int'(wreg_address) == a) return wdata();
    return model[a];
  endfunction
  task automatic tick();
    logic [31:0] nxt [32];
    for (int i = 0; i < 32; i++) nxt[i] = reset ? model[i] : 32'(i);
    if (reset && regwrite && wreg_address != 0) nxt[wreg_address] = wdata();
    @(posedge clock);
    for (int i = 0; i < 32; i++) model[i] = nxt[i];
    @(negedge clock);
  endtask
  task automatic test_reset();
    reset = 0; regwrite = 1; wreg_address = 3; alu_result = 32'hFFFF_FFFF;
    tick();
    reset = 1; regwrite = 0;
    for (int i = 0; i < 32; i++) begin
      instruction = mk(i, 31 - i, 0);
      #1;
      n_cmp++;
      if (register_rs !== 32'(i)) begin n_fail++; $display("FAIL reset_rs[%0d] got %h want %h", i, register_rs, 32'(i)); end
      n_cmp++;
      if (register_rt !== 32'(31 - i)) begin n_fail++; $display("FAIL reset_rt[%0d] got %h want %h", 31 - i, register_rt, 32'(31 - i)); end
    end
  endtask
  task automatic test_decode();
    regwrite = 0; instruction = 32'h014B_4820; #1;
    n_cmp++; if (register_rs !== 32'h0000_000A) begin n_fail++; $display("FAIL decode_rs got %h want 0000000a", register_rs); end
    n_cmp++; if (register_rt !== 32'h0000_000B) begin n_fail++; $display("FAIL decode_rt got %h want 0000000b", register_rt); end
    n_cmp++; if (wreg_rd !== 5'd9) begin n_fail++; $display("FAIL decode_rd got %0d want 9", wreg_rd); end
    n_cmp++; if (wreg_rt !== 5'd11) begin n_fail++; $display("FAIL decode_wrt got %0d want 11", wreg_rt); end
    n_cmp++; if (function_opcode !== 6'h20) begin n_fail++; $display("FAIL decode_funct got %h want 20", function_opcode); end
  endtask
  task automatic test_bypass();
    instruction = mk(9, 9, 0); regwrite = 1; memtoreg = 0; wreg_address = 9;
    alu_result = 32'h15; read_data = 32'hDEAD_BEEF; #1;
    n_cmp++; if (register_rs !== 32'h15) begin n_fail++; $display("FAIL bypass_rs got %h want 00000015", register_rs); end
    n_cmp++; if (register_rt !== 32'h15) begin n_fail++; $display("FAIL bypass_rt_same got %h want 00000015", register_rt); end
    tick();
    regwrite = 0; alu_result = 0; #1;
    n_cmp++; if (register_rs !== 32'h15) begin n_fail++; $display("FAIL bypass_stored got %h want 00000015", register_rs); end
  endtask
  task automatic test_zero_write();
    instruction = mk(0, 0, 0); regwrite = 1; memtoreg = 1; wreg_address = 0;
    read_data = 32'hDEAD_BEEF; #1;
    n_cmp++; if (register_rs !== 0) begin n_fail++; $display("FAIL zero_bypass_rs got %h want 0", register_rs); end
    n_cmp++; if (register_rt !== 0) begin n_fail++; $display("FAIL zero_bypass_rt got %h want 0", register_rt); end
    tick();
    regwrite = 0; #1;
    n_cmp++; if (register_rs !== 0) begin n_fail++; $display("FAIL zero_stored got %h want 0", register_rs); end
  endtask
  task automatic test_sign_extend();
    instruction = mk(1, 2, 16'h8004); #1;
    n_cmp++; if (sign_extend !== 32'hFFFF_8004) begin n_fail++; $display("FAIL sext_neg got %h want ffff8004", sign_extend); end
    instruction = mk(1, 2, 16'h7FFF); #1;
    n_cmp++; if (sign_extend !== 32'h0000_7FFF) begin n_fail++; $display("FAIL sext_pos got %h want 00007fff", sign_extend); end
  endtask
  task automatic test_reset_priority();
    instruction = mk(5, 6, 0); regwrite = 1; memtoreg = 0; wreg_address = 5; alu_result = 32'h1234_5678;
    tick();
    reset = 0; alu_result = 32'hFFFF_FFFF; #1;
    n_cmp++; if (register_rs !== 32'h1234_5678) begin n_fail++; $display("FAIL during_reset_rs got %h want 12345678", register_rs); end
    tick();
    reset = 1; regwrite = 0; #1;
    n_cmp++; if (register_rs !== 32'h5) begin n_fail++; $display("FAIL reset_priority got %h want 00000005", register_rs); end
  endtask
  task automatic test_first_write_after_reset();
    reset = 0; regwrite = 1; memtoreg = 1; wreg_address = 12; read_data = 32'h00C0_FFEE;
    instruction = mk(12, 13, 0);
    tick();
    reset = 1; #1;
    n_cmp++; if (register_rs !== 32'h00C0_FFEE) begin n_fail++; $display("FAIL post_reset_bypass got %h want 00c0ffee", register_rs); end
    tick();
    regwrite = 0; #1;
    n_cmp++; if (register_rs !== 32'h00C0_FFEE) begin n_fail++; $display("FAIL post_reset_write got %h want 00c0ffee", register_rs); end
  endtask
  task automatic test_no_write();
    instruction = mk(7, 7, 0); regwrite = 0; memtoreg = 0; wreg_address = 7; alu_result = 32'hAAAA_5555; #1;
    n_cmp++; if (register_rs !== 32'h7) begin n_fail++; $display("FAIL nowrite_comb got %h want 00000007", register_rs); end
    tick(); #1;
    n_cmp++; if (register_rs !== 32'h7) begin n_fail++; $display("FAIL nowrite_stored got %h want 00000007", register_rs); end
  endtask
  task automatic test_reset_glitch();
    instruction = mk(3, 4, 0); regwrite = 1; memtoreg = 0; wreg_address = 3; alu_result = 32'h33;
    tick();
    regwrite = 0; reset = 0; #2; reset = 1;
    tick(); #1;
    n_cmp++; if (register_rs !== 32'h33) begin n_fail++; $display("FAIL reset_glitch got %h want 00000033", register_rs); end
  endtask
  task automatic test_back_to_back();
    instruction = mk(20, 20, 0); regwrite = 1; memtoreg = 0; wreg_address = 20;
    for (int k = 1; k <= 7; k++) begin
      alu_result = 32'(k * 32'h11); #1;
      n_cmp++; if (register_rs !== 32'(k * 32'h11)) begin n_fail++; $display("FAIL b2b_bypass[%0d] got %h want %h", k, register_rs, 32'(k * 32'h11)); end
      tick();
    end
    regwrite = 0; #1;
    n_cmp++; if (register_rt !== 32'h77) begin n_fail++; $display("FAIL b2b_final got %h want 00000077", register_rt); end
  endtask
  task automatic test_random();
    int rs, rt;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 24) != 0);
      regwrite = $urandom_range(0, 1); memtoreg = $urandom_range(0, 1);
      wreg_address = 5'($urandom_range(0, 31));
      alu_result = $urandom; read_data = $urandom;
      rs = ($urandom_range(0, 2) == 0) ? int'(wreg_address) : int'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rs : int'($urandom_range(0, 31));
      instruction = mk(rs, rt, int'($urandom_range(0, 65535)));
      instruction[5:0] = 6'($urandom);
      #1;
      n_cmp++; if (register_rs !== exp_read(rs)) begin n_fail++; $display("FAIL rand_rs[%0d] got %h want %h", n, register_rs, exp_read(rs)); end
      n_cmp++; if (register_rt !== exp_read(rt)) begin n_fail++; $display("FAIL rand_rt[%0d] got %h want %h", n, register_rt, exp_read(rt)); end
      n_cmp++; if (sign_extend !== 32'(int'($signed(instruction[15:0])))) begin n_fail++; $display("FAIL rand_sext[%0d] got %h want %h", n, sign_extend, 32'(int'($signed(instruction[15:0])))); end
      n_cmp++; if (function_opcode !== 6'(instruction % 64)) begin n_fail++; $display("FAIL rand_funct[%0d] got %h want %h", n, function_opcode, 6'(instruction % 64)); end
      n_cmp++; if (wreg_rd !== 5'((instruction / 2048) % 32)) begin n_fail++; $display("FAIL rand_rd[%0d] got %0d want %0d", n, wreg_rd, (instruction / 2048) % 32); end
      n_cmp++; if (wreg_rt !== 5'(rt)) begin n_fail++; $display("FAIL rand_wrt[%0d] got %0d want %0d", n, wreg_rt, rt); end
      tick();
    end
    reset = 1; regwrite = 0;
    for (int i = 0; i < 32; i++) begin
      instruction = mk(i, 0, 0); #1;
      n_cmp++; if (register_rs !== exp_read(i)) begin n_fail++; $display("FAIL rand_final[%0d] got %h want %h", i, register_rs, exp_read(i)); end
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    @(negedge clock);
    test_reset();
    test_decode();
    test_bypass();
    test_zero_write();
    test_sign_extend();
    test_reset_priority();
    test_first_write_after_reset();
    test_no_write();
    test_reset_glitch();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
